// File: rtl/tlc_pkg.sv
// Shared types, default phase lengths and helpers for the traffic light sequencer.
// TLC_RED_YELLOW_EN adds the RED_YELLOW phase between RED and GREEN.
package tlc_pkg;

  typedef enum logic [1:0] {
    RED        = 2'd0,
    RED_YELLOW = 2'd1,
    GREEN      = 2'd2,
    YELLOW     = 2'd3
  } tlc_state_e;

  localparam int DEF_RED_CYCLES        = 10;
  localparam int DEF_GREEN_CYCLES      = 8;
  localparam int DEF_YELLOW_CYCLES     = 3;
  localparam int DEF_RED_YELLOW_CYCLES = 2;

  function automatic int phase_len(
    input tlc_state_e s,
    input int r,
    input int ry,
    input int g,
    input int y
  );
    case (s)
      RED_YELLOW: phase_len = ry;
      GREEN:      phase_len = g;
      YELLOW:     phase_len = y;
      default:    phase_len = r;
    endcase
  endfunction

  function automatic int max4(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Lamp bits are {red, yellow, green}.
  function automatic logic [2:0] lamps(input tlc_state_e s);
    case (s)
      RED_YELLOW: lamps = 3'b110;
      GREEN:      lamps = 3'b001;
      YELLOW:     lamps = 3'b010;
      default:    lamps = 3'b100;
    endcase
  endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// Phase cycle counter: clears on request, otherwise counts up;
// tc_o flags that the current count is the last cycle of the phase.
module tlc_phase_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic [CW-1:0] last_i,
  output logic          tc_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i) cnt_d = '0;
  end

  assign tc_o = (cnt_q == last_i);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/traffic_light_controller.sv
// Moore traffic light sequencer RED -> GREEN -> YELLOW -> RED.
// Define TLC_RED_YELLOW_EN to insert a RED_YELLOW phase before GREEN.
module traffic_light_controller
  import tlc_pkg::*;
#(
  parameter int RED_CYCLES        = DEF_RED_CYCLES,
  parameter int GREEN_CYCLES      = DEF_GREEN_CYCLES,
  parameter int YELLOW_CYCLES     = DEF_YELLOW_CYCLES,
  parameter int RED_YELLOW_CYCLES = DEF_RED_YELLOW_CYCLES
) (
  input  logic clk,
  input  logic reset,
  output logic red,
  output logic yellow,
  output logic green
);

`ifdef TLC_RED_YELLOW_EN
  localparam int MAXL = max4(RED_CYCLES, RED_YELLOW_CYCLES,
                             GREEN_CYCLES, YELLOW_CYCLES);
`else
  localparam int MAXL = max4(RED_CYCLES, 1,
                             GREEN_CYCLES, YELLOW_CYCLES);
`endif
  localparam int CW = (MAXL > 1) ? $clog2(MAXL) : 1;

  tlc_state_e    state_q, state_d;
  logic [2:0]    lamps_q;
  logic [CW-1:0] last;
  logic          tc;
  logic          clr;

  assign last = CW'(phase_len(state_q, RED_CYCLES, RED_YELLOW_CYCLES,
                              GREEN_CYCLES, YELLOW_CYCLES) - 1);

  tlc_phase_timer #(
    .CW(CW)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (clr),
    .last_i (last),
    .tc_o   (tc)
  );

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    case (state_q)
      RED: begin
        if (tc) begin
          clr = 1'b1;
`ifdef TLC_RED_YELLOW_EN
          state_d = RED_YELLOW;
`else
          state_d = GREEN;
`endif
        end
      end
      RED_YELLOW: begin
`ifdef TLC_RED_YELLOW_EN
        if (tc) begin
          clr     = 1'b1;
          state_d = GREEN;
        end
`else
        // Unreachable in the base build: fall back to RED.
        clr     = 1'b1;
        state_d = RED;
`endif
      end
      GREEN: begin
        if (tc) begin
          clr     = 1'b1;
          state_d = YELLOW;
        end
      end
      YELLOW: begin
        if (tc) begin
          clr     = 1'b1;
          state_d = RED;
        end
      end
      default: begin
        clr     = 1'b1;
        state_d = RED;
      end
    endcase
  end

  // Lamps are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RED;
      lamps_q <= 3'b100;
    end else begin
      state_q <= state_d;
      lamps_q <= lamps(state_d);
    end
  end

  assign red    = lamps_q[2];
  assign yellow = lamps_q[1];
  assign green  = lamps_q[0];

endmodule

// File: tb/tb_traffic_light_controller.sv
// Directed bench for traffic_light_controller: default and minimum-length
// instances, reset behaviour, full periods and a long soak run.
module tb_traffic_light_controller;

`ifdef TLC_RED_YELLOW_EN
  localparam int RY = 2;
`else
  localparam int RY = 0;
`endif
  localparam int R = 10;
  localparam int G = 8;
  localparam int Y = 3;
  localparam int P = R + RY + G + Y;

  logic clk;
  logic reset;
  logic d_red, d_yel, d_grn;
  logic m_red, m_yel, m_grn;
  logic [2:0] dl, ml;

  int passed;
  int total;

  assign dl = {d_red, d_yel, d_grn};
  assign ml = {m_red, m_yel, m_grn};

  traffic_light_controller u_def (
    .clk    (clk),
    .reset  (reset),
    .red    (d_red),
    .yellow (d_yel),
    .green  (d_grn)
  );

  traffic_light_controller #(
    .RED_CYCLES        (1),
    .GREEN_CYCLES      (1),
    .YELLOW_CYCLES     (1),
    .RED_YELLOW_CYCLES (1)
  ) u_min (
    .clk    (clk),
    .reset  (reset),
    .red    (m_red),
    .yellow (m_yel),
    .green  (m_grn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected lamps for 1-based cycle c after reset release (default lengths).
  function automatic logic [2:0] exp_def(input int c);
    int pos;
    pos = (c - 1) % P;
    if (pos < R)           return 3'b100;
    if (pos < R + RY)      return 3'b110;
    if (pos < R + RY + G)  return 3'b001;
    return 3'b010;
  endfunction

  function automatic logic [2:0] exp_min(input int c);
`ifdef TLC_RED_YELLOW_EN
    case ((c - 1) % 4)
      0: return 3'b100;
      1: return 3'b110;
      2: return 3'b001;
      default: return 3'b010;
    endcase
`else
    case ((c - 1) % 3)
      0: return 3'b100;
      1: return 3'b001;
      default: return 3'b010;
    endcase
`endif
  endfunction

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    reset = 1'b1;
    #1;
    total++;
    if (dl !== 3'b100)
      $display("FAIL reset_async_def got=%b want=100", dl);
    else passed++;
    total++;
    if (ml !== 3'b100)
      $display("FAIL reset_async_min got=%b want=100", ml);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (dl !== 3'b100)
        $display("FAIL reset_hold cyc=%0d got=%b want=100", i, dl);
      else passed++;
    end
  endtask

  task automatic test_full_cycle();
    release_reset();
    total++;
    if (dl !== exp_def(1))
      $display("FAIL full_c1 got=%b want=%b", dl, exp_def(1));
    else passed++;
    for (int k = 1; k <= P + 1; k++) begin
      @(posedge clk);
      #1;
      total++;
      if (dl !== exp_def(k + 1))
        $display("FAIL full_cycle c=%0d got=%b want=%b",
                 k + 1, dl, exp_def(k + 1));
      else passed++;
`ifndef TLC_RED_YELLOW_EN
      total++;
      if (!$onehot(dl))
        $display("FAIL onehot c=%0d got=%b want=onehot", k + 1, dl);
      else passed++;
`endif
    end
  endtask

  task automatic test_reset_mid_green();
    reset = 1'b1;
    release_reset();
    for (int k = 1; k <= R + RY + 3; k++) @(posedge clk);
    #1;
    total++;
    if (dl !== 3'b001)
      $display("FAIL pre_reset_green got=%b want=001", dl);
    else passed++;
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (dl !== 3'b100)
      $display("FAIL mid_green_async got=%b want=100", dl);
    else passed++;
    release_reset();
    for (int k = 1; k <= R; k++) begin
      @(posedge clk);
      #1;
      total++;
      if (dl !== exp_def(k + 1))
        $display("FAIL after_mid_reset c=%0d got=%b want=%b",
                 k + 1, dl, exp_def(k + 1));
      else passed++;
    end
  endtask

  task automatic test_min_lengths();
    reset = 1'b1;
    release_reset();
    total++;
    if (ml !== 3'b100)
      $display("FAIL min_c1 got=%b want=100", ml);
    else passed++;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      #1;
      total++;
      if (ml !== exp_min(k + 1))
        $display("FAIL min_rotate c=%0d got=%b want=%b",
                 k + 1, ml, exp_min(k + 1));
      else passed++;
    end
  endtask

  task automatic test_long_run();
    reset = 1'b1;
    release_reset();
    for (int k = 1; k <= 1000; k++) begin
      @(posedge clk);
      #1;
      total++;
      if (dl === 3'b000 || dl === 3'b111 || dl !== exp_def(k + 1))
        $display("FAIL long_run c=%0d got=%b want=%b",
                 k + 1, dl, exp_def(k + 1));
      else passed++;
    end
  endtask

  initial begin
    reset  = 1'b0;
    passed = 0;
    total  = 0;
    test_reset();
    test_full_cycle();
    test_reset_mid_green();
    test_min_lengths();
    test_long_run();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
